morse_decode_buf: RTL and testbench

MORSE_DECODE_BUF -- requirements
Module: morse_decode_buf

---
 rtl/morse_decode_buf.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_morse_decode_buf.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decode_buf.sv
// -----------------------------------------------------------------------------
// morse_decode_buf
//   Collects dot/dash elements into a group, decodes each group to ASCII after
//   a letter gap, inserts a single space after a word gap, keeps a COLS-wide
//   line buffer and repaints it onto a character LCD one column at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | accept clr/del/element events, run the gap timer
//   DECODE | one cycle: look the group up, append it, pulse char_valid
//   REDRAW | write columns 0..COLS-1 to the LCD with a req/done handshake
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   enable              low forces IDLE and clears all state
//   sym_valid/sym_dash  element strobe and type (0 = dot, 1 = dash)
//   del_req / clr_req   delete last character / clear line
//   unit_cycles         letter-gap threshold (word gap is twice this)
//   lcd_busy/lcd_done   LCD writer status
//   lcd_req/col/char    LCD write request
//   char_valid/data     pulse per decoded character or inserted space
//   sym_ovf             current group has more than MAX_SYMS elements
// -----------------------------------------------------------------------------
module morse_decode_buf #(
    parameter int COLS     = 16,
    parameter int MAX_SYMS = 6,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    sym_valid,
    input  logic                    sym_dash,
    input  logic                    del_req,
    input  logic                    clr_req,
    input  logic [CNT_W-1:0]        unit_cycles,
    input  logic                    lcd_busy,
    input  logic                    lcd_done,
    output logic                    lcd_req,
    output logic [$clog2(COLS)-1:0] lcd_col,
    output logic [7:0]              lcd_char,
    output logic                    char_valid,
    output logic [7:0]              char_data,
    output logic                    sym_ovf
);

    localparam int COL_W = $clog2(COLS);
    localparam int CUR_W = $clog2(COLS + 1);
    localparam int LEN_W = $clog2(MAX_SYMS + 1);
    localparam int GAP_W = CNT_W + 1;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] QMARK = 8'h3F;

    typedef enum logic [1:0] {IDLE, DECODE, REDRAW} state_t;

    state_t                  state_q, state_d;
    logic [COLS-1:0][7:0]    line_q, line_d;
    logic [CUR_W-1:0]        cursor_q, cursor_d;
    logic [MAX_SYMS-1:0]     code_q, code_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    ovf_q, ovf_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    lcd_req_q, lcd_req_d;
    logic [COL_W-1:0]        lcd_col_q, lcd_col_d;
    logic [7:0]              lcd_char_q, lcd_char_d;
    logic                    char_valid_q, char_valid_d;
    logic [7:0]              char_data_q, char_data_d;

    logic [CNT_W-1:0]        unit_eff;
    logic [GAP_W-1:0]        thresh_letter, thresh_word;
    logic [CUR_W-1:0]        cur_m1;
    logic                    last_is_space;
    logic                    letter_hit, word_hit, redraw_last_done;
    logic                    do_append;
    logic [7:0]              app_ch;

    // Group code is stored first-element-in-bit-0; the lookup rebuilds it in
    // reading order so the table below reads like the Morse chart.
    function automatic logic [7:0] morse_lookup(input logic [LEN_W-1:0]    len,
                                                input logic [MAX_SYMS-1:0] code);
        logic [7:0]  m;
        logic [11:0] key;
        logic [7:0]  ch;
        m = '0;
        for (int i = 0; i < MAX_SYMS; i++) begin
            if (i < int'(len)) m = {m[6:0], code[i]};
        end
        key = {4'(len), m};
        case (key)
            {4'd2, 8'b01}:     ch = "A";
            {4'd4, 8'b1000}:   ch = "B";
            {4'd4, 8'b1010}:   ch = "C";
            {4'd3, 8'b100}:    ch = "D";
            {4'd1, 8'b0}:      ch = "E";
            {4'd4, 8'b0010}:   ch = "F";
            {4'd3, 8'b110}:    ch = "G";
            {4'd4, 8'b0000}:   ch = "H";
            {4'd2, 8'b00}:     ch = "I";
            {4'd4, 8'b0111}:   ch = "J";
            {4'd3, 8'b101}:    ch = "K";
            {4'd4, 8'b0100}:   ch = "L";
            {4'd2, 8'b11}:     ch = "M";
            {4'd2, 8'b10}:     ch = "N";
            {4'd3, 8'b111}:    ch = "O";
            {4'd4, 8'b0110}:   ch = "P";
            {4'd4, 8'b1101}:   ch = "Q";
            {4'd3, 8'b010}:    ch = "R";
            {4'd3, 8'b000}:    ch = "S";
            {4'd1, 8'b1}:      ch = "T";
            {4'd3, 8'b001}:    ch = "U";
            {4'd4, 8'b0001}:   ch = "V";
            {4'd3, 8'b011}:    ch = "W";
            {4'd4, 8'b1001}:   ch = "X";
            {4'd4, 8'b1011}:   ch = "Y";
            {4'd4, 8'b1100}:   ch = "Z";
            {4'd5, 8'b11111}:  ch = "0";
            {4'd5, 8'b01111}:  ch = "1";
            {4'd5, 8'b00111}:  ch = "2";
            {4'd5, 8'b00011}:  ch = "3";
            {4'd5, 8'b00001}:  ch = "4";
            {4'd5, 8'b00000}:  ch = "5";
            {4'd5, 8'b10000}:  ch = "6";
            {4'd5, 8'b11000}:  ch = "7";
            {4'd5, 8'b11100}:  ch = "8";
            {4'd5, 8'b11110}:  ch = "9";
            {4'd6, 8'b010101}: ch = ".";
            {4'd6, 8'b110011}: ch = ",";
            {4'd6, 8'b001100}: ch = "?";
            default:           ch = QMARK;
        endcase
        return ch;
    endfunction

    // A zero threshold would make the letter gap fire on the accepting cycle.
    assign unit_eff      = (unit_cycles == '0) ? CNT_W'(1) : unit_cycles;
    assign thresh_letter = {1'b0, unit_eff};
    assign thresh_word   = {unit_eff, 1'b0};

    assign cur_m1        = cursor_q - CUR_W'(1);
    assign last_is_space = (line_q[cur_m1[COL_W-1:0]] == SPACE);

    assign letter_hit       = (gap_q == thresh_letter) && (len_q != '0);
    assign word_hit         = (gap_q == thresh_word) && (len_q == '0) &&
                              (cursor_q != '0) && !last_is_space;
    assign redraw_last_done = lcd_req_q && lcd_done &&
                              (lcd_col_q == COL_W'(COLS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req)                          state_d = REDRAW;
                    else if (del_req)                     state_d = (cursor_q != '0) ? REDRAW : IDLE;
                    else if (sym_valid)                   state_d = IDLE;
                    else if (letter_hit)                  state_d = DECODE;
                    else if (word_hit)                    state_d = REDRAW;
                end
                DECODE:                                   state_d = REDRAW;
                REDRAW: if (redraw_last_done)             state_d = IDLE;
                default:                                  state_d = IDLE;
            endcase
        end
    end

    // Output and datapath logic
    always_comb begin
        line_d       = line_q;
        cursor_d     = cursor_q;
        code_d       = code_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        gap_d        = gap_q;
        lcd_req_d    = lcd_req_q;
        lcd_col_d    = lcd_col_q;
        lcd_char_d   = lcd_char_q;
        char_valid_d = 1'b0;
        char_data_d  = char_data_q;
        do_append    = 1'b0;
        app_ch       = SPACE;

        if (!enable) begin
            line_d      = {COLS{SPACE}};
            cursor_d    = '0;
            code_d      = '0;
            len_d       = '0;
            ovf_d       = 1'b0;
            gap_d       = '0;
            lcd_req_d   = 1'b0;
            lcd_col_d   = '0;
            lcd_char_d  = SPACE;
            char_data_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        line_d    = {COLS{SPACE}};
                        cursor_d  = '0;
                        code_d    = '0;
                        len_d     = '0;
                        ovf_d     = 1'b0;
                        gap_d     = '0;
                        lcd_col_d = '0;
                    end else if (del_req) begin
                        // Delete on an empty line is a no-op.
                        if (cursor_q != '0) begin
                            line_d[cur_m1[COL_W-1:0]] = SPACE;
                            cursor_d  = cur_m1;
                            code_d    = '0;
                            len_d     = '0;
                            ovf_d     = 1'b0;
                            gap_d     = '0;
                            lcd_col_d = '0;
                        end
                    end else if (sym_valid) begin
                        gap_d = '0;
                        if (len_q < LEN_W'(MAX_SYMS)) begin
                            code_d[len_q] = sym_dash;
                            len_d         = len_q + LEN_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (letter_hit) begin
                        gap_d = gap_q;
                    end else if (word_hit) begin
                        do_append    = 1'b1;
                        app_ch       = SPACE;
                        char_valid_d = 1'b1;
                        char_data_d  = SPACE;
                        lcd_col_d    = '0;
                    end else if (gap_q >= thresh_word) begin
                        gap_d = thresh_word;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end

                DECODE: begin
                    do_append    = 1'b1;
                    app_ch       = ovf_q ? QMARK : morse_lookup(len_q, code_q);
                    char_valid_d = 1'b1;
                    char_data_d  = app_ch;
                    code_d       = '0;
                    len_d        = '0;
                    ovf_d        = 1'b0;
                    lcd_col_d    = '0;
                end

                REDRAW: begin
                    if (lcd_req_q) begin
                        if (lcd_done) begin
                            lcd_req_d = 1'b0;
                            if (lcd_col_q == COL_W'(COLS - 1)) begin
                                lcd_col_d = '0;
                                gap_d     = '0;
                            end else begin
                                lcd_col_d = lcd_col_q + COL_W'(1);
                            end
                        end
                    end else if (!lcd_busy) begin
                        // Only raised from a low request, so every done is
                        // followed by at least one idle cycle on lcd_req.
                        lcd_req_d  = 1'b1;
                        lcd_char_d = line_q[lcd_col_q];
                    end
                end

                default: ;
            endcase
        end

        // A full line scrolls left so the newest character is always visible.
        if (do_append) begin
            if (cursor_q < CUR_W'(COLS)) begin
                line_d[cursor_q[COL_W-1:0]] = app_ch;
                cursor_d = cursor_q + CUR_W'(1);
            end else begin
                for (int i = 0; i < COLS - 1; i++) begin
                    line_d[i] = line_q[i+1];
                end
                line_d[COLS-1] = app_ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q       <= {COLS{SPACE}};
            cursor_q     <= '0;
            code_q       <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            gap_q        <= '0;
            lcd_req_q    <= 1'b0;
            lcd_col_q    <= '0;
            lcd_char_q   <= SPACE;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
        end else begin
            line_q       <= line_d;
            cursor_q     <= cursor_d;
            code_q       <= code_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            gap_q        <= gap_d;
            lcd_req_q    <= lcd_req_d;
            lcd_col_q    <= lcd_col_d;
            lcd_char_q   <= lcd_char_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
        end
    end

    assign lcd_req    = lcd_req_q;
    assign lcd_col    = lcd_col_q;
    assign lcd_char   = lcd_char_q;
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign sym_ovf    = ovf_q;

endmodule

// File: tb/tb_morse_decode_buf.sv
// -----------------------------------------------------------------------------
// tb_morse_decode_buf
//   Directed bench for morse_decode_buf (COLS=16, MAX_SYMS=6, unit_cycles=10).
//   An LCD responder answers each request with lcd_done three cycles later and
//   keeps a shadow copy of the display; a monitor records char_valid pulses.
// -----------------------------------------------------------------------------
module tb_morse_decode_buf;

    logic        clk = 1'b0;
    logic        rst_n, enable, sym_valid, sym_dash, del_req, clr_req;
    logic [31:0] unit_cycles;
    logic        lcd_busy, lcd_done;
    logic        lcd_req;
    logic [3:0]  lcd_col;
    logic [7:0]  lcd_char;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        sym_ovf;

    morse_decode_buf dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sym_valid   (sym_valid),
        .sym_dash    (sym_dash),
        .del_req     (del_req),
        .clr_req     (clr_req),
        .unit_cycles (unit_cycles),
        .lcd_busy    (lcd_busy),
        .lcd_done    (lcd_done),
        .lcd_req     (lcd_req),
        .lcd_col     (lcd_col),
        .lcd_char    (lcd_char),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .sym_ovf     (sym_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LCD responder / display shadow
    logic [7:0] lcd_mem [16];
    int         wr_cnt = 0;
    int         rcnt   = 0;
    logic [3:0] cap_col;
    logic [7:0] cap_ch;
    time        last_done_t = 0;

    always @(negedge clk) begin
        if (lcd_req) begin
            rcnt = rcnt + 1;
            if (rcnt == 1) begin
                cap_col = lcd_col;
                cap_ch  = lcd_char;
            end
            if (rcnt == 3) begin
                lcd_done = 1'b1;
                checks   = checks + 1;
                if (lcd_col != cap_col || lcd_char != cap_ch) begin
                    errors = errors + 1;
                    $display("FAIL lcd_stable: col %0d char %h, held col %0d char %h",
                             lcd_col, lcd_char, cap_col, cap_ch);
                end
                lcd_mem[lcd_col] = lcd_char;
                wr_cnt      = wr_cnt + 1;
                last_done_t = $time;
            end else begin
                lcd_done = 1'b0;
            end
        end else begin
            rcnt     = 0;
            lcd_done = 1'b0;
        end
    end

    // char_valid monitor
    int         cv_cnt = 0;
    logic [7:0] cv_last = '0;
    time        cv_t = 0;

    always @(negedge clk) begin
        if (char_valid) begin
            cv_cnt  = cv_cnt + 1;
            cv_last = char_data;
            cv_t    = $time;
        end
    end

    time t_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic d);
        sym_dash  = d;
        sym_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        sym_valid = 1'b0;
        sym_dash  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_sym(s[i] == "-");
            step();
            step();
        end
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    task automatic pulse_del();
        del_req = 1'b1;
        step();
        del_req = 1'b0;
    endtask

    task automatic wait_cv(input int n, input int budget);
        int k = 0;
        while (cv_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks = checks + 1;
        if (cv_cnt < n) begin
            errors = errors + 1;
            $display("FAIL wait_char: got %0d pulses want %0d", cv_cnt, n);
        end
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while (wr_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks = checks + 1;
        if (wr_cnt < n) begin
            errors = errors + 1;
            $display("FAIL wait_redraw: got %0d writes want %0d", wr_cnt, n);
        end
    endtask

    task automatic clear_line();
        int wb = wr_cnt;
        pulse_clr();
        wait_wr(wb + 16, 200);
    endtask

    task automatic type_char(input string s);
        int cb = cv_cnt;
        int wb = wr_cnt;
        send_str(s);
        wait_cv(cb + 1, 60);
        wait_wr(wb + 16, 200);
    endtask

    typedef struct {
        string      syms;
        logic [7:0] exp_ch;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic set_vec(input int i, input string s, input logic [7:0] c, input logic o);
        vecs[i].syms    = s;
        vecs[i].exp_ch  = c;
        vecs[i].exp_ovf = o;
    endtask

    initial begin
        int  cb, wb, lat, any_req, wr_at_rst;
        time sp_ref;

        set_vec(0,  ".-",      8'h41, 1'b0);
        set_vec(1,  "-...",    8'h42, 1'b0);
        set_vec(2,  "-.-.",    8'h43, 1'b0);
        set_vec(3,  "...-",    8'h56, 1'b0);
        set_vec(4,  "--..",    8'h5A, 1'b0);
        set_vec(5,  "-----",   8'h30, 1'b0);
        set_vec(6,  ".----",   8'h31, 1'b0);
        set_vec(7,  "----.",   8'h39, 1'b0);
        set_vec(8,  ".-.-.-",  8'h2E, 1'b0);
        set_vec(9,  "--..--",  8'h2C, 1'b0);
        set_vec(10, "..--..",  8'h3F, 1'b0);
        set_vec(11, ".......", 8'h3F, 1'b1);
        set_vec(12, "...---",  8'h3F, 1'b0);

        for (int i = 0; i < 16; i++) lcd_mem[i] = 8'h00;
        rst_n = 1'b0; enable = 1'b1; sym_valid = 1'b0; sym_dash = 1'b0;
        del_req = 1'b0; clr_req = 1'b0; unit_cycles = 32'd10;
        lcd_busy = 1'b0; lcd_done = 1'b0;

        repeat (3) step();
        chk("rst_lcd_req",    lcd_req,    0);
        chk("rst_lcd_col",    lcd_col,    0);
        chk("rst_lcd_char",   lcd_char,   8'h20);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_data",  char_data,  0);
        chk("rst_sym_ovf",    sym_ovf,    0);
        rst_n = 1'b1;
        step();

        // 'A' from a fresh line: latency, one pulse, full 16-column redraw
        clear_line();
        cb = cv_cnt; wb = wr_cnt;
        send_str(".-");
        wait_cv(cb + 1, 60);
        lat = int'((cv_t - t_acc - 5) / 10);
        chk_range("a_latency", lat, 10, 14);
        chk("a_char", cv_last, 8'h41);
        wait_wr(wb + 16, 200);
        chk("a_pulses", cv_cnt - cb, 1);
        chk("a_writes", wr_cnt - wb, 16);
        chk("a_col0", lcd_mem[0], 8'h41);
        for (int i = 1; i < 16; i++) chk("a_blank", lcd_mem[i], 8'h20);

        // Decode table
        clear_line();
        for (int v = 0; v < 13; v++) begin
            cb = cv_cnt; wb = wr_cnt;
            send_str(vecs[v].syms);
            chk({"ovf_pre ", vecs[v].syms}, sym_ovf, vecs[v].exp_ovf);
            wait_cv(cb + 1, 60);
            chk({"dec ", vecs[v].syms}, cv_last, vecs[v].exp_ch);
            wait_wr(wb + 16, 200);
            chk({"lcd ", vecs[v].syms}, lcd_mem[v], vecs[v].exp_ch);
            chk({"ovf_post ", vecs[v].syms}, sym_ovf, 0);
        end

        // 17 x 'E' then 'T': line scrolls, cursor pinned at the last column
        clear_line();
        cb = cv_cnt;
        for (int n = 0; n < 17; n++) type_char(".");
        chk("e17_pulses", cv_cnt - cb, 17);
        for (int i = 0; i < 16; i++) chk("e17_col", lcd_mem[i], 8'h45);
        type_char("-");
        chk("scroll_col15", lcd_mem[15], 8'h54);
        chk("scroll_col14", lcd_mem[14], 8'h45);
        chk("scroll_col0",  lcd_mem[0],  8'h45);

        // "AB" then delete
        clear_line();
        type_char(".-");
        type_char("-...");
        cb = cv_cnt; wb = wr_cnt;
        pulse_del();
        wait_wr(wb + 16, 200);
        chk("del_col0", lcd_mem[0], 8'h41);
        chk("del_col1", lcd_mem[1], 8'h20);
        chk("del_pulses", cv_cnt - cb, 0);

        // lcd_busy holds off the first request
        lcd_busy = 1'b1;
        wb = wr_cnt;
        pulse_clr();
        any_req = 0;
        repeat (10) begin step(); if (lcd_req) any_req = 1; end
        chk("busy_no_req", any_req, 0);
        lcd_busy = 1'b0;
        wait_wr(wb + 16, 200);

        // delete on empty line: no LCD traffic
        wb = wr_cnt;
        pulse_del();
        any_req = 0;
        repeat (30) begin step(); if (lcd_req) any_req = 1; end
        chk("del_empty_req", any_req, 0);
        chk("del_empty_writes", wr_cnt - wb, 0);

        // 'E', element during redraw dropped, single space after word gap
        cb = cv_cnt; wb = wr_cnt;
        send_str(".");
        wait_cv(cb + 1, 60);
        repeat (3) step();
        send_sym(1'b0);
        wait_wr(wb + 16, 200);
        sp_ref = last_done_t;
        cb = cv_cnt; wb = wr_cnt;
        repeat (130) step();
        chk("space_pulses", cv_cnt - cb, 1);
        chk("space_char", cv_last, 8'h20);
        lat = int'((cv_t - sp_ref) / 10);
        chk_range("space_latency", lat, 19, 24);
        chk("space_writes", wr_cnt - wb, 16);
        chk("space_col0", lcd_mem[0], 8'h45);
        chk("space_col1", lcd_mem[1], 8'h20);

        // Reset mid-redraw aborts it
        pulse_clr();
        repeat (8) step();
        rst_n = 1'b0;
        wr_at_rst = wr_cnt;
        step();
        chk("mid_rst_lcd_req",    lcd_req,    0);
        chk("mid_rst_lcd_col",    lcd_col,    0);
        chk("mid_rst_lcd_char",   lcd_char,   8'h20);
        chk("mid_rst_char_valid", char_valid, 0);
        chk("mid_rst_char_data",  char_data,  0);
        chk("mid_rst_sym_ovf",    sym_ovf,    0);
        rst_n = 1'b1;
        repeat (120) step();
        chk("mid_rst_aborted", wr_cnt, wr_at_rst);

        // enable low with a pending group: no decode, line cleared
        clear_line();
        type_char(".");
        type_char(".");
        send_sym(1'b1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        cb = cv_cnt;
        repeat (40) step();
        chk("en_no_decode", cv_cnt - cb, 0);
        type_char(".");
        chk("en_char", cv_last, 8'h45);
        chk("en_col0", lcd_mem[0], 8'h45);
        chk("en_col1", lcd_mem[1], 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
